// File: rtl/multicycle_borrow_subtractor.sv
// multicycle_borrow_subtractor
//   Computes in1 - in2 (mod 2^N) one 4-bit slice per cycle, LSB slice first,
//   rippling the slice borrow through a register. The result is
//   published after N/4 BUSY cycles and is held until the consumer takes it.
//
//   Optional macro SUB_OPSEL_EN adds an 'op' input (1=subtract, 0=add).
//   Without the macro the block always subtracts.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   op                (SUB_OPSEL_EN only) operation select, captured on accept
//   start / in_ready  request handshake; operands accepted when both are 1
//   in1, in2          minuend / subtrahend (N bits)
//   diff              result (N bits)
//   bout              final borrow (or carry when adding)
//   of                signed overflow flag
//   out_valid         diff/bout/of valid
//   out_ready         consumer accepts result when out_valid is also 1
module multicycle_borrow_subtractor #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SUB_OPSEL_EN
    input  logic         op,
`endif
    input  logic         start,
    output logic         in_ready,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         of,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int NS = N / 4;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  a_q, b_q, res_q, diff_q;
    logic [CW-1:0] cnt_q;
    logic          bor_q, sub_q, bout_q, of_q, out_valid_q, in_ready_q;

    logic          sub_sel;
    logic [4:0]    slice_d;
    logic [N-1:0]  res_d;
    logic          of_d;

`ifdef SUB_OPSEL_EN
    assign sub_sel = op;
`else
    assign sub_sel = 1'b1;
`endif

    // One slice per cycle. Bit 4 of the 5-bit result is the slice borrow
    // (subtract) or carry (add); it feeds the next slice via bor_q.
    always_comb begin
        slice_d = '0;
        res_d   = res_q;
        of_d    = 1'b0;
        if (sub_q)
            slice_d = {1'b0, a_q[{cnt_q, 2'b00} +: 4]} - {1'b0, b_q[{cnt_q, 2'b00} +: 4]}
                      - {4'b0, bor_q};
        else
            slice_d = {1'b0, a_q[{cnt_q, 2'b00} +: 4]} + {1'b0, b_q[{cnt_q, 2'b00} +: 4]}
                      + {4'b0, bor_q};
        res_d[{cnt_q, 2'b00} +: 4] = slice_d[3:0];
        // Only meaningful on the last slice, where slice_d[3] is diff[N-1].
        if (sub_q)
            of_d = (a_q[N-1] ^ b_q[N-1]) & (a_q[N-1] ^ slice_d[3]);
        else
            of_d = ~(a_q[N-1] ^ b_q[N-1]) & (a_q[N-1] ^ slice_d[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            bor_q       <= 1'b0;
            sub_q       <= 1'b1;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            of_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q        <= in1;
                        b_q        <= in2;
                        sub_q      <= sub_sel;
                        bor_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    res_q <= res_d;
                    bor_q <= slice_d[4];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // Result registers change only here, so they hold
                        // the last result across IDLE and the next BUSY.
                        diff_q      <= res_d;
                        bout_q      <= slice_d[4];
                        of_q        <= of_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign diff      = diff_q;
    assign bout      = bout_q;
    assign of        = of_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule
